// File: rtl/or_gate_bist.sv
// Built-in self-test sequencer for a two-input OR gate.
// Walks {a,b} through 11,10,01,00, samples r after SETTLE cycles, and logs mismatches.
module or_gate_bist #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned LOOPS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_r,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] LOOPS_LAST  = 8'(LOOPS - 1);

    state_t     state;
    logic [1:0] idx;
    logic [7:0] settle_cnt;
    logic [7:0] loop_cnt;

    logic       sample;
    logic       mismatch;
    logic       last_vec;
    logic [1:0] next_idx;
    logic [7:0] err_next;

    assign sample   = (settle_cnt == SETTLE_LAST);
    assign mismatch = (gate_r != (gate_a | gate_b));
    assign last_vec = (idx == 2'd0) && (loop_cnt == LOOPS_LAST);
    assign next_idx = idx - 2'd1;

    // Count that includes the current sample, saturating at 255.
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != 8'hFF)) begin
            err_next = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 8'd0;
            loop_cnt   <= 8'd0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 8'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        idx        <= 2'd3;
                        settle_cnt <= 8'd0;
                        loop_cnt   <= 8'd0;
                        gate_a     <= 1'b1;
                        gate_b     <= 1'b1;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= 8'd0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'd0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        settle_cnt <= 8'd0;
                        err_count  <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= {gate_a, gate_b};
                        end
                        if (last_vec) begin
                            state  <= DONE;
                            gate_a <= 1'b0;
                            gate_b <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (err_next == 8'd0);
                        end else begin
                            idx    <= next_idx;
                            gate_a <= next_idx[1];
                            gate_b <= next_idx[0];
                            if (idx == 2'd0) begin
                                loop_cnt <= loop_cnt + 8'd1;
                            end
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
